// File: rtl/mem_access_arbiter_pkg.sv
// mem_access_arbiter_pkg: shared constants for the ARC main-memory access sequencer.
// Rev 1.0
`default_nettype none

package mem_access_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/mem_access_arbiter_rr.sv
// mem_access_arbiter_rr: combinational 2-way round-robin grant (fetch vs data port).
// Rev 1.0
`default_nettype none

module mem_access_arbiter_rr
  import mem_access_arbiter_pkg::*;
(
  input  logic fetch_req,
  input  logic data_req,
  input  logic last_served,
  output logic winner
);

  // On a tie the port that was not served last wins; the encoding makes that an inversion.
  always_comb begin
    winner = REQ_FETCH;
    if (fetch_req && data_req) begin
      winner = ~last_served;
    end else if (data_req) begin
      winner = REQ_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: grants fetch/data ports to main memory one at a time, runs one
// transaction with ACK timeout and returns data with a one-cycle Ack pulse. Rev 1.0
`default_nettype none

module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     MEM_ACCESS_ARBITER_CLOCK_50,
  input  logic                     MEM_ACCESS_ARBITER_ResetInLow_In,
  input  logic                     MEM_ACCESS_ARBITER_FetchReq_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_FetchAddr_InBus,
  output logic                     MEM_ACCESS_ARBITER_FetchAck_Out,
  input  logic                     MEM_ACCESS_ARBITER_DataReq_In,
  input  logic                     MEM_ACCESS_ARBITER_DataWR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_DataAddr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_DataWData_InBus,
  output logic                     MEM_ACCESS_ARBITER_DataAck_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_RData_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_MemA_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_MemB_OutBus,
  output logic                     MEM_ACCESS_ARBITER_MemRD_Out,
  output logic                     MEM_ACCESS_ARBITER_MemWRMain_Out,
  input  logic                     MEM_ACCESS_ARBITER_MemACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_ARBITER_MemData_InBus,
  output logic                     MEM_ACCESS_ARBITER_Busy_Out,
  output logic                     MEM_ACCESS_ARBITER_Err_Out
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]               state;
  logic                     last_served;
  logic                     winner_q;
  logic                     op_q;
  logic                     err_q;
  logic [DATAWIDTH_BUS-1:0] addr_q;
  logic [DATAWIDTH_BUS-1:0] wdata_q;
  logic [DATAWIDTH_BUS-1:0] rdata_q;
  logic [CNT_W-1:0]         tmo_cnt;
  logic                     grant;
  logic                     any_req;
  logic                     timeout_hit;

  assign any_req     = MEM_ACCESS_ARBITER_FetchReq_In | MEM_ACCESS_ARBITER_DataReq_In;
  assign timeout_hit = (tmo_cnt == TMO_LAST);

  mem_access_arbiter_rr u_rr (
    .fetch_req   (MEM_ACCESS_ARBITER_FetchReq_In),
    .data_req    (MEM_ACCESS_ARBITER_DataReq_In),
    .last_served (last_served),
    .winner      (grant)
  );

  always_ff @(posedge MEM_ACCESS_ARBITER_CLOCK_50) begin
    if (!MEM_ACCESS_ARBITER_ResetInLow_In) begin
      state       <= ST_IDLE;
      last_served <= REQ_DATA;
      winner_q    <= REQ_FETCH;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state       <= ST_ACCESS;
            winner_q    <= grant;
            last_served <= grant;
            tmo_cnt     <= '0;
            // Fetch is read-only and has no write data, so the B bus keeps its last value.
            if (grant == REQ_DATA) begin
              op_q    <= MEM_ACCESS_ARBITER_DataWR_In;
              addr_q  <= MEM_ACCESS_ARBITER_DataAddr_InBus;
              wdata_q <= MEM_ACCESS_ARBITER_DataWData_InBus;
            end else begin
              op_q    <= 1'b0;
              addr_q  <= MEM_ACCESS_ARBITER_FetchAddr_InBus;
            end
          end
        end
        ST_ACCESS: begin
          if (MEM_ACCESS_ARBITER_MemACK_In) begin
            state   <= ST_DONE;
            rdata_q <= op_q ? '0 : MEM_ACCESS_ARBITER_MemData_InBus;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            state   <= ST_DONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MEM_ACCESS_ARBITER_MemA_OutBus   = addr_q;
  assign MEM_ACCESS_ARBITER_MemB_OutBus   = wdata_q;
  assign MEM_ACCESS_ARBITER_MemRD_Out     = (state == ST_ACCESS) & ~op_q;
  assign MEM_ACCESS_ARBITER_MemWRMain_Out = (state == ST_ACCESS) &  op_q;
  assign MEM_ACCESS_ARBITER_FetchAck_Out  = (state == ST_DONE) & (winner_q == REQ_FETCH);
  assign MEM_ACCESS_ARBITER_DataAck_Out   = (state == ST_DONE) & (winner_q == REQ_DATA);
  assign MEM_ACCESS_ARBITER_Err_Out       = (state == ST_DONE) & err_q;
  assign MEM_ACCESS_ARBITER_Busy_Out      = (state != ST_IDLE);
  assign MEM_ACCESS_ARBITER_RData_OutBus  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: transaction-level reference model with per-cycle compare.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_arbiter;

  localparam int DW = 32;
  localparam int T  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, fetch_req, data_req, data_wr, mem_ack;
  logic [DW-1:0] fetch_addr, data_addr, data_wdata, mem_data;
  logic          fetch_ack, data_ack, mem_rd, mem_wr, busy, err;
  logic [DW-1:0] rdata, mem_a, mem_b;

  mem_access_arbiter #(.DATAWIDTH_BUS(DW), .TIMEOUT_CYCLES(T)) dut (
    .MEM_ACCESS_ARBITER_CLOCK_50        (clk),
    .MEM_ACCESS_ARBITER_ResetInLow_In   (rst_n),
    .MEM_ACCESS_ARBITER_FetchReq_In     (fetch_req),
    .MEM_ACCESS_ARBITER_FetchAddr_InBus (fetch_addr),
    .MEM_ACCESS_ARBITER_FetchAck_Out    (fetch_ack),
    .MEM_ACCESS_ARBITER_DataReq_In      (data_req),
    .MEM_ACCESS_ARBITER_DataWR_In       (data_wr),
    .MEM_ACCESS_ARBITER_DataAddr_InBus  (data_addr),
    .MEM_ACCESS_ARBITER_DataWData_InBus (data_wdata),
    .MEM_ACCESS_ARBITER_DataAck_Out     (data_ack),
    .MEM_ACCESS_ARBITER_RData_OutBus    (rdata),
    .MEM_ACCESS_ARBITER_MemA_OutBus     (mem_a),
    .MEM_ACCESS_ARBITER_MemB_OutBus     (mem_b),
    .MEM_ACCESS_ARBITER_MemRD_Out       (mem_rd),
    .MEM_ACCESS_ARBITER_MemWRMain_Out   (mem_wr),
    .MEM_ACCESS_ARBITER_MemACK_In       (mem_ack),
    .MEM_ACCESS_ARBITER_MemData_InBus   (mem_data),
    .MEM_ACCESS_ARBITER_Busy_Out        (busy),
    .MEM_ACCESS_ARBITER_Err_Out         (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected outputs for the current cycle, written by the model just after each edge.
  bit            chk_on = 1'b0;
  bit            chk_rdata = 1'b0;
  logic          exp_fack, exp_dack, exp_busy, exp_rd, exp_wr, exp_err;
  logic [DW-1:0] exp_a, exp_b, exp_rdata;

  // Model state: which port was served last, and what the A/B buses are holding.
  bit            last_data = 1'b1;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;
  int            sample_cyc = 0;

  // Observations of each Ack pulse, used by the hand-computed checks.
  int            obs_cnt = 0;
  int            obs_lat = -1;
  int            n_dack  = 0;
  int            n_wr_cycles = 0;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  bit            obs_q[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("fetch_ack", 32'(fetch_ack), 32'(exp_fack));
      check("data_ack",  32'(data_ack),  32'(exp_dack));
      check("busy",      32'(busy),      32'(exp_busy));
      check("mem_rd",    32'(mem_rd),    32'(exp_rd));
      check("mem_wr",    32'(mem_wr),    32'(exp_wr));
      check("err",       32'(err),       32'(exp_err));
      check("mem_a",     mem_a,          exp_a);
      check("mem_b",     mem_b,          exp_b);
      if (chk_rdata) check("rdata", rdata, exp_rdata);
      if (fetch_ack || data_ack) begin
        obs_cnt++;
        obs_rdata = rdata;
        obs_err   = err;
        obs_lat   = cyc - sample_cyc + 1;
        obs_q.push_back(data_ack);
        if (data_ack) n_dack++;
      end
      if (mem_wr) n_wr_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_fack = 0; exp_dack = 0; exp_busy = 0; exp_rd = 0; exp_wr = 0; exp_err = 0;
    exp_a = m_a; exp_b = m_b; chk_rdata = 0;
  endtask

  task automatic exp_after_reset();
    m_a = '0; m_b = '0; last_data = 1'b1;
    exp_idle();
    chk_rdata = 1; exp_rdata = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 0; fetch_req = 0; data_req = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_on = 1'b1;
      exp_after_reset();
    end
    rst_n = 1;
  endtask

  // One arbitration round starting in an IDLE cycle. k = memory wait cycles before ACK,
  // md = read data presented with ACK, rst_at = ACCESS cycle in which reset is asserted (-1 none).
  task automatic txn(input bit fr, input bit dr, input logic [DW-1:0] fa, input logic [DW-1:0] da,
                     input bit dwr, input logic [DW-1:0] dwd, input int k,
                     input logic [DW-1:0] md, input int rst_at);
    bit            win_data, op, tmo;
    int            n_acc;
    logic [DW-1:0] cap;
    fetch_req = fr; data_req = dr; fetch_addr = fa; data_addr = da;
    data_wr = dwr; data_wdata = dwd;
    mem_ack = 1'($urandom); mem_data = $urandom;
    if (!fr && !dr) begin
      tick();
      exp_idle();
      return;
    end
    win_data  = (fr && dr) ? !last_data : dr;
    last_data = win_data;
    op        = win_data && dwr;
    m_a       = win_data ? da : fa;
    if (win_data) m_b = dwd;
    n_acc      = (k < T - 1) ? k : T - 1;
    tmo        = (k > T - 1);
    sample_cyc = cyc + 1;
    cap        = '0;
    for (int i = 0; i <= n_acc; i++) begin
      tick();
      exp_idle();
      exp_busy = 1; exp_rd = !op; exp_wr = op;
      if (i == rst_at) begin
        rst_n = 0;
        tick();
        exp_after_reset();
        rst_n = 1; fetch_req = 0; data_req = 0;
        return;
      end
      if ($urandom_range(3) == 0) fetch_req = 0;
      if ($urandom_range(3) == 0) data_req = 0;
      mem_ack  = (i == k);
      mem_data = (i == n_acc) ? md : $urandom;
      if (i == n_acc) cap = md;
    end
    tick();
    exp_idle();
    exp_busy = 1;
    exp_fack = !win_data; exp_dack = win_data; exp_err = tmo;
    chk_rdata = 1; exp_rdata = (tmo || op) ? '0 : cap;
    mem_ack = 1'($urandom); mem_data = $urandom;
    tick();
    exp_idle();
  endtask

  initial begin
    int c0;
    rst_n = 0; fetch_req = 0; data_req = 0; data_wr = 0; mem_ack = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_data = '0;
    do_reset(2);

    // Tied requests from reset alternate starting with fetch.
    obs_q.delete();
    for (int i = 0; i < 4; i++) txn(1, 1, 32'h100 + i, 32'h200 + i, 0, 32'h0, 0, $urandom, -1);
    check("tie_count", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < obs_q.size(); i++) check("tie_order", 32'(obs_q[i]), 32'(i % 2));

    c0 = n_dack;
    txn(1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h9080200A, -1);
    check("fetch_latency", 32'(obs_lat), 32'd2);
    check("fetch_rdata", obs_rdata, 32'h9080200A);
    check("fetch_err", 32'(obs_err), 32'd0);
    check("fetch_no_dack", 32'(n_dack - c0), 32'd0);

    c0 = n_wr_cycles;
    txn(0, 1, 32'h0, 32'h5, 1, 32'hDEADBEEF, 0, $urandom, -1);
    check("write_strobe_cycles", 32'(n_wr_cycles - c0), 32'd1);
    check("write_rdata", obs_rdata, 32'h0);
    check("write_memA_hold", mem_a, 32'h5);
    check("write_memB_hold", mem_b, 32'hDEADBEEF);

    txn(1, 0, 32'h40, 32'h0, 0, 32'h0, 1000, 32'h1111, -1);
    check("timeout_latency", 32'(obs_lat), 32'd17);
    check("timeout_err", 32'(obs_err), 32'd1);
    check("timeout_rdata", obs_rdata, 32'h0);
    txn(1, 0, 32'h44, 32'h0, 0, 32'h0, 0, 32'h1234, -1);
    check("post_timeout_err", 32'(obs_err), 32'd0);
    check("post_timeout_rdata", obs_rdata, 32'h1234);

    txn(0, 1, 32'h0, 32'h80, 0, 32'h0, 3, 32'h55AA55AA, -1);
    check("wait3_latency", 32'(obs_lat), 32'd5);
    check("wait3_rdata", obs_rdata, 32'h55AA55AA);
    txn(1, 0, 32'h84, 32'h0, 0, 32'h0, 15, 32'hCAFEF00D, -1);
    check("ack_on_last_latency", 32'(obs_lat), 32'd17);
    check("ack_on_last_err", 32'(obs_err), 32'd0);
    check("ack_on_last_rdata", obs_rdata, 32'hCAFEF00D);

    // Data wins this tie (fetch served last), then reset in flight hands the next tie to fetch.
    c0 = obs_cnt;
    txn(1, 1, 32'h90, 32'h94, 0, 32'h0, 5, 32'h0, 2);
    check("reset_no_ack", 32'(obs_cnt - c0), 32'd0);
    txn(1, 1, 32'h98, 32'h9C, 0, 32'h0, 0, 32'h0, -1);
    check("reset_tie_fetch", 32'(obs_q[obs_q.size() - 1]), 32'd0);

    for (int n = 0; n < 250; n++) begin
      int r, k, ra;
      r  = $urandom_range(9);
      k  = (r < 7) ? $urandom_range(3) : ((r < 9) ? $urandom_range(20, 12) : $urandom_range(15));
      ra = ($urandom_range(24) == 0) ? $urandom_range((k < T - 1) ? k : T - 1) : -1;
      txn(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, k, $urandom, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
